// File: rtl/cdu_pkg.sv
// Shared types and constants for the countermeasure dispatch unit.
// Range defaults are shared with the threat-analysis unit so both agree on metres.
package cdu_pkg;

    typedef enum logic [1:0] {
        CDU_IDLE     = 2'd0,
        CDU_DEPLOY   = 2'd1,
        CDU_COOLDOWN = 2'd2
    } cdu_state_t;

    localparam logic [1:0] BURST_CLOSE = 2'd3;
    localparam logic [1:0] BURST_MID   = 2'd2;
    localparam logic [1:0] BURST_FAR   = 2'd1;

    localparam int unsigned CLOSE_RANGE_DEF = 5000;
    localparam int unsigned MID_RANGE_DEF   = 12000;

endpackage

// File: rtl/cdu_burst_sizer.sv
// Maps target distance to a flare burst size, clamped to the
// flares still on board so the inventory can never underflow.
module cdu_burst_sizer
    import cdu_pkg::*;
#(
    parameter int unsigned CLOSE_RANGE = CLOSE_RANGE_DEF,
    parameter int unsigned MID_RANGE   = MID_RANGE_DEF
) (
    input  logic [31:0] distance,
    input  logic [7:0]  inventory,
    output logic [1:0]  burst
);

    logic [1:0] range_burst;

    // Strict range compares, then clamp to inventory
    always_comb begin
        range_burst = BURST_FAR;
        if (distance < 32'(CLOSE_RANGE))
            range_burst = BURST_CLOSE;
        else if (distance < 32'(MID_RANGE))
            range_burst = BURST_MID;
        burst = range_burst;
        if (inventory < {6'd0, range_burst})
            burst = inventory[1:0];
    end

endmodule

// File: rtl/countermeasure_dispatch_unit.sv
// Sequences flare bursts on threat detection: range-scaled burst,
// fixed strobe spacing, post-burst cooldown, and inventory reload.
module countermeasure_dispatch_unit
    import cdu_pkg::*;
#(
    parameter int unsigned FLARE_GAP       = 2,
    parameter int unsigned COOLDOWN_CYCLES = 10,
    parameter int unsigned CLOSE_RANGE     = CLOSE_RANGE_DEF,
    parameter int unsigned MID_RANGE       = MID_RANGE_DEF,
    parameter int unsigned MAX_FLARES      = 16,
    parameter int unsigned INIT_FLARES     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        threat_detected,
    input  logic [31:0] distance_to_target,
    input  logic        reload,
    input  logic [7:0]  reload_count,
    output logic        flare_release,
    output logic [7:0]  flares_remaining,
    output logic [31:0] last_threat_distance,
    output logic        inventory_empty,
    output logic [1:0]  CDU_state
);

    localparam int GW = $clog2(FLARE_GAP + 2);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

    cdu_state_t    state;
    logic [GW-1:0] gap_cnt;
    logic [CW-1:0] cool_cnt;
    logic [1:0]    released;
    logic [1:0]    burst_r;
    logic [1:0]    burst_n;
    logic [8:0]    reload_sum;

    cdu_burst_sizer #(
        .CLOSE_RANGE (CLOSE_RANGE),
        .MID_RANGE   (MID_RANGE)
    ) u_sizer (
        .distance  (distance_to_target),
        .inventory (flares_remaining),
        .burst     (burst_n)
    );

    assign reload_sum      = {1'b0, flares_remaining} + {1'b0, reload_count};
    assign flare_release   = (state == CDU_DEPLOY) && (gap_cnt == '0);
    assign inventory_empty = (flares_remaining == 8'd0);
    assign CDU_state       = state;

    // Engagement FSM with gap/cooldown counters and inventory bookkeeping
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state                <= CDU_IDLE;
            gap_cnt              <= '0;
            cool_cnt             <= '0;
            released             <= 2'd0;
            burst_r              <= 2'd0;
            flares_remaining     <= 8'(INIT_FLARES);
            last_threat_distance <= 32'd0;
        end else begin
            unique case (state)
                CDU_IDLE: begin
                    if (threat_detected && flares_remaining != 8'd0) begin
                        state                <= CDU_DEPLOY;
                        last_threat_distance <= distance_to_target;
                        burst_r              <= burst_n;
                        released             <= 2'd0;
                        gap_cnt              <= '0;
                    end else if (reload) begin
                        if (reload_sum > 9'(MAX_FLARES))
                            flares_remaining <= 8'(MAX_FLARES);
                        else
                            flares_remaining <= reload_sum[7:0];
                    end
                end
                CDU_DEPLOY: begin
                    if (gap_cnt == '0) begin
                        flares_remaining <= flares_remaining - 8'd1;
                        released         <= released + 2'd1;
                        gap_cnt          <= GW'(FLARE_GAP);
                        if (released + 2'd1 == burst_r) begin
                            state    <= CDU_COOLDOWN;
                            cool_cnt <= CW'(COOLDOWN_CYCLES - 1);
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                CDU_COOLDOWN: begin
                    if (cool_cnt == '0)
                        state <= CDU_IDLE;
                    else
                        cool_cnt <= cool_cnt - 1'b1;
                end
                default: state <= CDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_countermeasure_dispatch_unit.sv
// Bench for countermeasure_dispatch_unit: strobe timing scoreboard
// plus directed inventory, state and reset checks.
module tb_countermeasure_dispatch_unit;

    localparam int GAP  = 2;
    localparam int COOL = 10;
    localparam int CLOSE = 5000;
    localparam int MID  = 12000;
    localparam int MAXF = 16;
    localparam int INIT = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        threat_detected = 1'b0;
    logic [31:0] distance_to_target = 32'd0;
    logic        reload = 1'b0;
    logic [7:0]  reload_count = 8'd0;
    logic        flare_release;
    logic [7:0]  flares_remaining;
    logic [31:0] last_threat_distance;
    logic        inventory_empty;
    logic [1:0]  CDU_state;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int inv = INIT;
    int sb[$];

    countermeasure_dispatch_unit dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .threat_detected      (threat_detected),
        .distance_to_target   (distance_to_target),
        .reload               (reload),
        .reload_count         (reload_count),
        .flare_release        (flare_release),
        .flares_remaining     (flares_remaining),
        .last_threat_distance (last_threat_distance),
        .inventory_empty      (inventory_empty),
        .CDU_state            (CDU_state)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_burst(input int unsigned d, input int n);
        int r;
        r = (d < CLOSE) ? 3 : (d < MID) ? 2 : 1;
        return (r < n) ? r : n;
    endfunction

    // Each strobe must match the next expected strobe cycle
    always @(negedge CLK) begin
        if (flare_release === 1'b1) begin
            if (sb.size() == 0)
                chk("unexpected_strobe", flare_release, 0);
            else
                chk("strobe_cyc", cyc, sb.pop_front());
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        inv = INIT;
    endtask

    task automatic engage(input logic [31:0] d, input logic rl,
                          input logic [7:0] rc, output int last_s);
        int b;
        int n;
        @(negedge CLK);
        b = exp_burst(d, inv);
        n = cyc;
        distance_to_target = d;
        threat_detected = 1'b1;
        reload = rl;
        reload_count = rc;
        for (int i = 0; i < b; i++)
            sb.push_back(n + 1 + i * (GAP + 1));
        last_s = n + 1 + (b - 1) * (GAP + 1);
        inv -= b;
        @(negedge CLK);
        threat_detected = 1'b0;
        reload = 1'b0;
    endtask

    task automatic finish_burst(input int last_s, input string tag);
        wait_until(last_s + COOL);
        chk({tag, "_cool"}, CDU_state, 2);
        wait_until(last_s + COOL + 1);
        chk({tag, "_idle"}, CDU_state, 0);
        chk({tag, "_inv"}, flares_remaining, inv);
        chk({tag, "_sb"}, sb.size(), 0);
    endtask

    task automatic do_reload(input logic [7:0] c);
        @(negedge CLK);
        reload = 1'b1;
        reload_count = c;
        @(negedge CLK);
        reload = 1'b0;
        inv = (inv + c > MAXF) ? MAXF : inv + c;
        chk("reload_inv", flares_remaining, inv);
    endtask

    initial begin
        int ls;
        int n;

        #2;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_state", CDU_state, 0);
        chk("rst_inv", flares_remaining, INIT);
        chk("rst_dist", last_threat_distance, 0);
        chk("rst_rel", flare_release, 0);
        chk("rst_empty", inventory_empty, 0);

        engage(32'd4000, 1'b0, 8'd0, ls);
        chk("deploy_state", CDU_state, 1);
        finish_burst(ls, "close");
        chk("close_dist", last_threat_distance, 4000);

        do_reset();
        engage(32'd12000, 1'b0, 8'd0, ls);
        finish_burst(ls, "mid_edge");
        engage(32'd5000, 1'b0, 8'd0, ls);
        finish_burst(ls, "close_edge");
        chk("close_edge_dist", last_threat_distance, 5000);
        engage(32'd4999, 1'b0, 8'd0, ls);
        finish_burst(ls, "close_in");

        engage(32'd20000, 1'b0, 8'd0, ls);
        finish_burst(ls, "far");
        chk("one_left", flares_remaining, 1);
        engage(32'd3000, 1'b0, 8'd0, ls);
        finish_burst(ls, "clamp");
        chk("empty", inventory_empty, 1);

        @(negedge CLK);
        distance_to_target = 32'd3000;
        threat_detected = 1'b1;
        repeat (6) @(negedge CLK);
        chk("empty_state", CDU_state, 0);
        chk("empty_inv", flares_remaining, 0);
        threat_detected = 1'b0;

        do_reload(8'd10);
        do_reload(8'd20);

        engage(32'd8000, 1'b0, 8'd0, ls);
        wait_until(ls + 3);
        reload = 1'b1;
        reload_count = 8'd5;
        @(negedge CLK);
        reload = 1'b0;
        finish_burst(ls, "cool_reload");

        engage(32'd12000, 1'b1, 8'd5, ls);
        finish_burst(ls, "eng_wins");

        do_reset();
        @(negedge CLK);
        n = cyc;
        distance_to_target = 32'd8000;
        threat_detected = 1'b1;
        sb.push_back(n + 1);
        sb.push_back(n + 4);
        sb.push_back(n + 4 + COOL + 2);
        sb.push_back(n + 7 + COOL + 2);
        wait_until(n + 4 + COOL + 1);
        chk("held_idle", CDU_state, 0);
        chk("held_inv1", flares_remaining, 6);
        wait_until(n + 7 + COOL + 2 + COOL);
        threat_detected = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("held_state", CDU_state, 0);
        chk("held_inv2", flares_remaining, 4);
        chk("held_sb", sb.size(), 0);

        do_reset();
        @(negedge CLK);
        n = cyc;
        distance_to_target = 32'd4000;
        threat_detected = 1'b1;
        sb.push_back(n + 1);
        @(negedge CLK);
        threat_detected = 1'b0;
        @(negedge CLK);
        chk("pre_rst_inv", flares_remaining, 7);
        #2 RST = 1'b1;
        #1;
        chk("arst_state", CDU_state, 0);
        chk("arst_inv", flares_remaining, INIT);
        chk("arst_dist", last_threat_distance, 0);
        chk("arst_rel", flare_release, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (15) @(negedge CLK);
        chk("arst_after_inv", flares_remaining, INIT);
        chk("arst_after_state", CDU_state, 0);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
